raster_cmd_queue: RTL and testbench
===================================

Name: raster_cmd_queue

Overview:
- Parametrised command queue between the CPU core and the raster GPU; the next generation of the CPU-GPU command path.
- Buffers up to DEPTH raster commands from the CPU side.
- Issues them one at a time on the GPU interface with a one-cycle gpu_execute_request pulse, and never issues while the GPU is busy.
- Adds flush, occupancy count and sticky overflow reporting, so the CPU need not poll gpu_busy per command.

Parameters:
- DEPTH, 16, queue entries; power of two, >= 2.
- COORD_W, 8, width of each coordinate.
- COLOUR_W, 3, width of colour.
- BUSY_WAIT, 1, cycles after a request during which gpu_busy is not trusted (GPU busy-assert latency); >= 1.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_async  in  1  reset; synchronous, active-high
- push  in  1  enqueue push_* fields this cycle
- push_command  in  raster_command_t  raster command
- push_x0, push_y0, push_x1, push_y1  in  COORD_W each  coordinates
- push_colour  in  COLOUR_W  colour
- flush  in  1  discard all queued (not yet issued) entries
- clear_overflow  in  1  clear sticky overflow
- full  out  1  queue holds DEPTH entries
- empty  out  1  queue holds 0 entries
- count  out  $clog2(DEPTH+1)  occupancy
- overflow  out  1  sticky: a push was dropped
- gpu_command  out  raster_command_t  issued command
- gpu_x0, gpu_y0, gpu_x1, gpu_y1  out  COORD_W each  issued coordinates
- gpu_colour  out  COLOUR_W  issued colour
- gpu_execute_request  out  1  one-cycle issue pulse
- gpu_busy  in  1  GPU executing

Behaviour:
- Reset: FIFO emptied; full=0, empty=1, count=0, overflow=0, gpu_execute_request=0, all gpu_* data outputs 0; FSM enters IDLE. Applies mid-operation: an in-flight request is dropped, and the GPU command already started is not tracked.
- All outputs are registered. gpu_* data holds the last issued entry until the next issue.
- Push accepted iff push && !full && !flush.
- Push while full: dropped; overflow set the next cycle. Entries leaving the queue in the same cycle do not make room.
- Flush: count=0 next cycle; does not affect the FSM or a command already issued. Push in the same cycle as flush is dropped without setting overflow.
- clear_overflow and an overflow-setting push in the same cycle: overflow stays set (set wins).
- count/full/empty update the cycle after push/pop. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH.
- FSM:
  - IDLE: if !empty && !gpu_busy at clock edge -> ISSUE. At that edge the head entry is popped into the gpu_* registers and gpu_execute_request <= 1.
  - ISSUE: lasts exactly 1 cycle; gpu_execute_request = 1 -> GUARD. The request drops to 0 at the exit edge.
  - GUARD: counter runs BUSY_WAIT cycles; gpu_busy ignored -> WAIT.
  - WAIT: when gpu_busy == 0 -> IDLE.
- Latency: push sampled at edge E into an empty queue with the GPU idle gives gpu_execute_request high in the cycle after edge E+1, i.e. 2 cycles.
- Maximum issue rate: one command per 3+BUSY_WAIT cycles when gpu_busy never asserts.
- gpu_execute_request is never high while gpu_busy was high at the issuing edge.
- gpu_execute_request is never high in consecutive cycles.

Decomposition:
- Package common gains raster_entry_t: packed struct {raster_command_t command; x0, y0, x1, y1; colour}, built with default widths 8/3.
- If COORD_W/COLOUR_W are non-default, the entry is a flat local packed vector instead.
- FSM state enum raster_queue_state_t (IDLE, ISSUE, GUARD, WAIT) is local to the module.
- One sub-module: sync_fifo (WIDTH, DEPTH; push, pop, flush, full, empty, count, rd_data show-ahead). Reusable for a future sound queue.

Test Plan:
- Reset then push LINE (10,10)->(100,100) colour 3'b110, gpu_busy=0 -> request pulse 2 cycles after push; gpu_* match; request high exactly 1 cycle; count 1 then 0.
- Push 3 entries back-to-back; bench raises gpu_busy 1 cycle after each request and holds it 20 cycles -> 3 requests in FIFO order, each 1 cycle after busy falls plus the IDLE edge; none while busy.
- gpu_busy held high; push DEPTH+2 entries -> full=1 at count 16; overflow=1 after the 17th push; count stays 16; clear_overflow -> overflow=0.
- Queue holding 5 entries, one command in flight -> flush with a simultaneous push: count=0, overflow=0, no further requests; in-flight gpu_* outputs unchanged.
- Assert rst_async during GUARD with 4 queued -> next cycle request=0, empty=1, count=0, gpu_* outputs=0; a new push issues normally with 2-cycle latency.
- Pointer wrap: 40 push/issue pairs with gpu_busy=0 -> all 40 issued in order, count never exceeds 1, no overflow.

Source files
------------

// File: rtl/raster_cmd_queue_pkg.sv
// Shared types for the CPU-to-GPU raster command path.
//   raster_command_t : raster operation code carried with every queue entry
//   raster_entry_t   : one queue entry at the default 8-bit coordinate /
//                      3-bit colour widths
//   entry_width()    : flat entry width for any coordinate/colour widths
package raster_cmd_queue_pkg;

  typedef enum logic [1:0] {
    RC_CLEAR = 2'd0,
    RC_PIXEL = 2'd1,
    RC_LINE  = 2'd2,
    RC_RECT  = 2'd3
  } raster_command_t;

  localparam int RC_COORD_W_DEF  = 8;
  localparam int RC_COLOUR_W_DEF = 3;

  typedef struct packed {
    raster_command_t              command;
    logic [RC_COORD_W_DEF-1:0]    x0;
    logic [RC_COORD_W_DEF-1:0]    y0;
    logic [RC_COORD_W_DEF-1:0]    x1;
    logic [RC_COORD_W_DEF-1:0]    y1;
    logic [RC_COLOUR_W_DEF-1:0]   colour;
  } raster_entry_t;

  function automatic int entry_width(input int coord_w, input int colour_w);
    return $bits(raster_command_t) + 4 * coord_w + colour_w;
  endfunction

endpackage

// File: rtl/raster_cmd_queue_sync_fifo.sv
// Generic single-clock FIFO with show-ahead read data.
//   clk, srst        : clock, synchronous active-high reset
//   push / wr_data   : write request and data (ignored when full or flushing)
//   pop              : consume the head entry (ignored when empty)
//   flush            : discard all stored entries
//   full/empty/count : registered occupancy status
//   rd_data          : current head entry, valid whenever !empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       srst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Full is judged on the registered state, so a same-cycle pop never
  // makes room for a push.
  assign do_push = push && !full_q && !flush;
  assign do_pop  = pop && !empty_q;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
    if (flush)                   count_d = '0;
  end

  // Pointers are DEPTH-sized (power of two) so they wrap by overflow.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/raster_cmd_queue.sv
// Command queue between the CPU and the raster GPU.
//   clk, rst_async        : clock, synchronous active-high reset
//   push, push_*          : enqueue one raster command
//   flush                 : drop every queued (not yet issued) command
//   clear_overflow        : clear the sticky overflow flag
//   full/empty/count      : queue occupancy
//   overflow              : sticky, a push was dropped because the queue was full
//   gpu_*                 : last issued command, held until the next issue
//   gpu_execute_request   : one-cycle pulse per issued command
//   gpu_busy              : GPU is executing a command
module raster_cmd_queue
  import raster_cmd_queue_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int COORD_W   = 8,
  parameter int COLOUR_W  = 3,
  parameter int BUSY_WAIT = 1
) (
  input  logic                       clk,
  input  logic                       rst_async,
  input  logic                       push,
  input  raster_command_t            push_command,
  input  logic [COORD_W-1:0]         push_x0,
  input  logic [COORD_W-1:0]         push_y0,
  input  logic [COORD_W-1:0]         push_x1,
  input  logic [COORD_W-1:0]         push_y1,
  input  logic [COLOUR_W-1:0]        push_colour,
  input  logic                       flush,
  input  logic                       clear_overflow,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output raster_command_t            gpu_command,
  output logic [COORD_W-1:0]         gpu_x0,
  output logic [COORD_W-1:0]         gpu_y0,
  output logic [COORD_W-1:0]         gpu_x1,
  output logic [COORD_W-1:0]         gpu_y1,
  output logic [COLOUR_W-1:0]        gpu_colour,
  output logic                       gpu_execute_request,
  input  logic                       gpu_busy
);

  localparam int ENTRY_W = entry_width(COORD_W, COLOUR_W);
  localparam int GW      = $clog2(BUSY_WAIT+1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(BUSY_WAIT-1);

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} raster_queue_state_t;

  logic [ENTRY_W-1:0]  wr_entry, rd_entry;
  logic [1:0]          rd_cmd_bits;
  logic [COORD_W-1:0]  rd_x0, rd_y0, rd_x1, rd_y1;
  logic [COLOUR_W-1:0] rd_colour;
  logic                fifo_full, fifo_empty, pop;
  logic                overflow_q, overflow_d;

  raster_queue_state_t state_q;
  logic [GW-1:0]       guard_cnt_q;
  logic                req_q;
  raster_command_t     gpu_command_q;
  logic [COORD_W-1:0]  gpu_x0_q, gpu_y0_q, gpu_x1_q, gpu_y1_q;
  logic [COLOUR_W-1:0] gpu_colour_q;

  // Default widths use the shared struct; other widths fall back to a
  // flat vector with the same field order.
  generate
    if (COORD_W == RC_COORD_W_DEF && COLOUR_W == RC_COLOUR_W_DEF) begin : g_struct
      raster_entry_t wr_s, rd_s;
      always_comb begin
        wr_s.command = push_command;
        wr_s.x0      = push_x0;
        wr_s.y0      = push_y0;
        wr_s.x1      = push_x1;
        wr_s.y1      = push_y1;
        wr_s.colour  = push_colour;
      end
      assign wr_entry    = wr_s;
      assign rd_s        = rd_entry;
      assign rd_cmd_bits = rd_s.command;
      assign rd_x0       = rd_s.x0;
      assign rd_y0       = rd_s.y0;
      assign rd_x1       = rd_s.x1;
      assign rd_y1       = rd_s.y1;
      assign rd_colour   = rd_s.colour;
    end else begin : g_flat
      assign wr_entry = {push_command, push_x0, push_y0, push_x1, push_y1, push_colour};
      assign {rd_cmd_bits, rd_x0, rd_y0, rd_x1, rd_y1, rd_colour} = rd_entry;
    end
  endgenerate

  // The head is popped on the same edge that latches it into gpu_*.
  assign pop = (state_q == IDLE) && !fifo_empty && !gpu_busy;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .srst    (rst_async),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count),
    .rd_data (rd_entry)
  );

  // A dropped push beats a simultaneous clear; a push dropped by flush
  // is intentional and never flags overflow.
  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow)                  overflow_d = 1'b0;
    if (push && fifo_full && !flush)     overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_async) overflow_q <= 1'b0;
    else           overflow_q <= overflow_d;
  end

  // GUARD covers the GPU's busy-assert latency: gpu_busy is not looked at
  // until BUSY_WAIT cycles after the request has dropped.
  always_ff @(posedge clk) begin
    if (rst_async) begin
      state_q       <= IDLE;
      guard_cnt_q   <= '0;
      req_q         <= 1'b0;
      gpu_command_q <= RC_CLEAR;
      gpu_x0_q      <= '0;
      gpu_y0_q      <= '0;
      gpu_x1_q      <= '0;
      gpu_y1_q      <= '0;
      gpu_colour_q  <= '0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            gpu_command_q <= raster_command_t'(rd_cmd_bits);
            gpu_x0_q      <= rd_x0;
            gpu_y0_q      <= rd_y0;
            gpu_x1_q      <= rd_x1;
            gpu_y1_q      <= rd_y1;
            gpu_colour_q  <= rd_colour;
            req_q         <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          guard_cnt_q <= '0;
          state_q     <= GUARD;
        end
        GUARD: begin
          if (guard_cnt_q == GUARD_LAST) state_q <= WAIT;
          else                           guard_cnt_q <= guard_cnt_q + 1'b1;
        end
        WAIT: begin
          if (!gpu_busy) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign full                = fifo_full;
  assign empty               = fifo_empty;
  assign overflow            = overflow_q;
  assign gpu_command         = gpu_command_q;
  assign gpu_x0              = gpu_x0_q;
  assign gpu_y0              = gpu_y0_q;
  assign gpu_x1              = gpu_x1_q;
  assign gpu_y1              = gpu_y1_q;
  assign gpu_colour          = gpu_colour_q;
  assign gpu_execute_request = req_q;

endmodule

// File: tb/tb_raster_cmd_queue.sv
// Directed self-checking bench for raster_cmd_queue (default parameters).
module tb_raster_cmd_queue;
  import raster_cmd_queue_pkg::*;

  logic            clk = 1'b0;
  logic            rst_async, push, flush, clear_overflow, gpu_busy;
  raster_command_t push_command, gpu_command;
  logic [7:0]      push_x0, push_y0, push_x1, push_y1;
  logic [7:0]      gpu_x0, gpu_y0, gpu_x1, gpu_y1;
  logic [2:0]      push_colour, gpu_colour;
  logic            full, empty, overflow, gpu_execute_request;
  logic [4:0]      count;
  raster_entry_t   gpu_e;

  int errors = 0;
  int checks = 0;

  assign gpu_e = {gpu_command, gpu_x0, gpu_y0, gpu_x1, gpu_y1, gpu_colour};

  always #10 clk = ~clk;

  raster_cmd_queue #(.DEPTH(16), .COORD_W(8), .COLOUR_W(3), .BUSY_WAIT(1)) dut (
    .clk(clk), .rst_async(rst_async), .push(push), .push_command(push_command),
    .push_x0(push_x0), .push_y0(push_y0), .push_x1(push_x1), .push_y1(push_y1),
    .push_colour(push_colour), .flush(flush), .clear_overflow(clear_overflow),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .gpu_command(gpu_command), .gpu_x0(gpu_x0), .gpu_y0(gpu_y0), .gpu_x1(gpu_x1),
    .gpu_y1(gpu_y1), .gpu_colour(gpu_colour),
    .gpu_execute_request(gpu_execute_request), .gpu_busy(gpu_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic raster_entry_t mk(input int i);
    raster_entry_t e;
    e.command = raster_command_t'(i[1:0]);
    e.x0      = 8'(i);
    e.y0      = 8'(i + 1);
    e.x1      = 8'(2 * i);
    e.y1      = 8'(255 - i);
    e.colour  = 3'(i);
    return e;
  endfunction

  task automatic drive(input raster_entry_t e);
    push         = 1'b1;
    push_command = e.command;
    push_x0      = e.x0;
    push_y0      = e.y0;
    push_x1      = e.x1;
    push_y1      = e.y1;
    push_colour  = e.colour;
  endtask

  task automatic do_reset();
    rst_async = 1'b1; push = 1'b0; flush = 1'b0; clear_overflow = 1'b0;
    step();
    rst_async = 1'b0;
  endtask

  task automatic test_reset();
    gpu_busy = 1'b0;
    drive(mk(0)); push = 1'b0;
    rst_async = 1'b1; flush = 1'b0; clear_overflow = 1'b0;
    step();
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (gpu_execute_request !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", gpu_execute_request); end
    checks++; if (gpu_e !== '0) begin errors++; $display("FAIL reset_gpu got=%h exp=0", gpu_e); end
    rst_async = 1'b0;
    step();
  endtask

  task automatic test_single();
    raster_entry_t e;
    e = {RC_LINE, 8'd10, 8'd10, 8'd100, 8'd100, 3'b110};
    drive(e);
    step();
    push = 1'b0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count1 got=%0d exp=1", count); end
    checks++; if (gpu_execute_request !== 1'b0) begin errors++; $display("FAIL single_req_early got=%b exp=0", gpu_execute_request); end
    step();
    checks++; if (gpu_execute_request !== 1'b1) begin errors++; $display("FAIL single_req got=%b exp=1", gpu_execute_request); end
    checks++; if (gpu_e !== e) begin errors++; $display("FAIL single_gpu got=%h exp=%h", gpu_e, e); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL single_count0 got=%0d exp=0", count); end
    step();
    checks++; if (gpu_execute_request !== 1'b0) begin errors++; $display("FAIL single_req_width got=%b exp=0", gpu_execute_request); end
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    raster_entry_t exp_a[3];
    int got = 0;
    int last_c = -100;
    logic prev_req = 1'b0;
    for (int i = 0; i < 3; i++) exp_a[i] = mk(i + 1);
    for (int c = 0; c < 100; c++) begin
      if (gpu_execute_request === 1'b1) begin
        checks++; if (gpu_busy !== 1'b0) begin errors++; $display("FAIL b2b_req_while_busy c=%0d busy=%b exp=0", c, gpu_busy); end
        checks++; if (prev_req !== 1'b0) begin errors++; $display("FAIL b2b_consecutive c=%0d prev=%b exp=0", c, prev_req); end
        if (got < 3) begin
          checks++; if (gpu_e !== exp_a[got]) begin errors++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", got, gpu_e, exp_a[got]); end
          if (got > 0) begin
            checks++; if (c - last_c != 23) begin errors++; $display("FAIL b2b_gap idx=%0d got=%0d exp=23", got, c - last_c); end
          end
        end else begin
          checks++; errors++; $display("FAIL b2b_extra_req c=%0d got=%0d exp=3", c, got + 1);
        end
        last_c = c;
        got++;
      end
      prev_req = gpu_execute_request;
      if (c < 3) drive(exp_a[c]); else push = 1'b0;
      if (c == last_c + 1)  gpu_busy = 1'b1;
      if (c == last_c + 21) gpu_busy = 1'b0;
      step();
    end
    gpu_busy = 1'b0;
    checks++; if (got != 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", got); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got=%b exp=1", empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    gpu_busy = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      drive(mk(i));
      step();
      checks++; if (count !== 5'((i > 16) ? 16 : i)) begin errors++; $display("FAIL ovf_count push=%0d got=%0d exp=%0d", i, count, (i > 16) ? 16 : i); end
      checks++; if (full !== (i >= 16)) begin errors++; $display("FAIL ovf_full push=%0d got=%b exp=%b", i, full, i >= 16); end
      checks++; if (overflow !== (i >= 17)) begin errors++; $display("FAIL ovf_flag push=%0d got=%b exp=%b", i, overflow, i >= 17); end
      checks++; if (gpu_execute_request !== 1'b0) begin errors++; $display("FAIL ovf_req push=%0d got=%b exp=0", i, gpu_execute_request); end
    end
    clear_overflow = 1'b1;
    step();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    push = 1'b0;
    step();
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count_hold got=%0d exp=16", count); end
  endtask

  task automatic test_flush();
    raster_entry_t a;
    logic seen = 1'b0;
    logic stray = 1'b0;
    do_reset();
    gpu_busy = 1'b0;
    a = mk(50);
    drive(a);
    step();
    push = 1'b0;
    for (int j = 0; j < 5 && !seen; j++) begin
      step();
      if (gpu_execute_request === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL flush_first_issue got=%b exp=1", seen); end
    gpu_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(mk(60 + i));
      step();
    end
    push = 1'b0;
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
    drive(mk(99));
    flush = 1'b1;
    step();
    push = 1'b0; flush = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b exp=1", empty); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow got=%b exp=0", overflow); end
    checks++; if (gpu_e !== a) begin errors++; $display("FAIL flush_inflight got=%h exp=%h", gpu_e, a); end
    gpu_busy = 1'b0;
    for (int j = 0; j < 12; j++) begin
      step();
      if (gpu_execute_request !== 1'b0) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL flush_stray_req got=%b exp=0", stray); end
  endtask

  task automatic test_reset_guard();
    raster_entry_t e;
    do_reset();
    gpu_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(mk(70 + i));
      step();
    end
    push = 1'b0;
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL rg_pre_count got=%0d exp=5", count); end
    gpu_busy = 1'b0;
    step();
    checks++; if (gpu_execute_request !== 1'b1) begin errors++; $display("FAIL rg_issue got=%b exp=1", gpu_execute_request); end
    checks++; if (gpu_e !== mk(70)) begin errors++; $display("FAIL rg_issue_data got=%h exp=%h", gpu_e, mk(70)); end
    gpu_busy = 1'b1;
    step();
    checks++; if (count !== 5'd4) begin errors++; $display("FAIL rg_guard_count got=%0d exp=4", count); end
    rst_async = 1'b1;
    step();
    rst_async = 1'b0;
    gpu_busy  = 1'b0;
    checks++; if (gpu_execute_request !== 1'b0) begin errors++; $display("FAIL rg_req got=%b exp=0", gpu_execute_request); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rg_empty got=%b exp=1", empty); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rg_count got=%0d exp=0", count); end
    checks++; if (gpu_e !== '0) begin errors++; $display("FAIL rg_gpu got=%h exp=0", gpu_e); end
    e = mk(80);
    drive(e);
    step();
    push = 1'b0;
    checks++; if (gpu_execute_request !== 1'b0) begin errors++; $display("FAIL rg_new_early got=%b exp=0", gpu_execute_request); end
    step();
    checks++; if (gpu_execute_request !== 1'b1) begin errors++; $display("FAIL rg_new_req got=%b exp=1", gpu_execute_request); end
    checks++; if (gpu_e !== e) begin errors++; $display("FAIL rg_new_data got=%h exp=%h", gpu_e, e); end
  endtask

  task automatic test_wrap();
    int max_count = 0;
    do_reset();
    gpu_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic found = 1'b0;
      drive(mk(100 + i));
      step();
      push = 1'b0;
      for (int j = 0; j < 8 && !found; j++) begin
        if (int'(count) > max_count) max_count = int'(count);
        if (gpu_execute_request === 1'b1) begin
          found = 1'b1;
          checks++; if (gpu_e !== mk(100 + i)) begin errors++; $display("FAIL wrap_data idx=%0d got=%h exp=%h", i, gpu_e, mk(100 + i)); end
        end else begin
          step();
        end
      end
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL wrap_timeout idx=%0d got=%b exp=1", i, found); end
    end
    checks++; if (max_count > 1) begin errors++; $display("FAIL wrap_max_count got=%0d exp<=1", max_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got=%b exp=0", overflow); end
  endtask

  initial begin
    rst_async = 1'b1; push = 1'b0; flush = 1'b0; clear_overflow = 1'b0; gpu_busy = 1'b0;
    push_command = RC_CLEAR; push_x0 = '0; push_y0 = '0; push_x1 = '0; push_y1 = '0; push_colour = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_reset_guard();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
